tn_sdram_responder: RTL and testbench
=====================================

Name: tn_sdram_responder

Overview:
- Synthesizable, BRAM-backed responder for the busy-handshake memory protocol that the DRAM_conRV adapter drives. It uses the read/write/refresh/busy/mask semantics of MemoryController.
- Serves as a drop-in replacement for MemoryController in FPGA builds that have no SDRAM, and as a cycle-accurate protocol responder in simulation.
- Models init delay, per-operation latency, refresh occupancy and out-of-range faults.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; valid word index is addr[31:2] < DEPTH_WORDS.
- READ_LAT, 4: cycles busy stays high for a read (>=1).
- WRITE_LAT, 3: cycles busy stays high for a write (>=1).
- REFRESH_LAT, 8: cycles busy stays high for a refresh (>=1).
- INIT_CYCLES, 16: cycles after reset release before mem_initialized rises (>=1).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- read  in  1  read request, level; the initiator holds it until it sees busy=1.
- write  in  1  write request, level; same rule as read.
- refresh  in  1  refresh request, level; same rule as read.
- addr  in  32  byte address; addr[1:0] ignored (word access).
- din  in  32  write data.
- mask  in  4  active-low byte mask; mask[i]=0 writes byte i (din[8i+7:8i]).
- dout  out  32  read data; valid when busy falls, held until the next read completes.
- busy  out  1  high during init and during each operation.
- mem_initialized  out  1  high once init completes.
- fail  out  1  sticky out-of-range access flag.
- total_written  out  16  count of committed writes, wraps at 16'hFFFF->0.

Behaviour:
- Reset (async, while rst=1):
  - state=INIT, busy=1, mem_initialized=0, dout=0, fail=0, total_written=0, latency counter=0.
  - Array contents are not reset.
  - Any in-flight write is dropped without commit; a read in flight does not update dout.
- States: INIT, IDLE, RD, WR, REF.
- INIT:
  - Counts INIT_CYCLES clocks after rst falls.
  - On the final count: ->IDLE, busy<=0, mem_initialized<=1 (stays 1 until the next reset).
  - Requests during INIT are ignored, not queued.
- IDLE (busy=0): samples requests each edge with priority refresh > write > read.
  - Acceptance edge N: busy<=1 in the same edge, so busy is high from cycle N+1.
  - Also at edge N: capture word index addr[31:2], din and mask; load the counter with LAT-1; go to REF, WR or RD.
- RD/WR/REF:
  - Counter decrements each cycle; requests are ignored.
  - When the counter is 0: busy<=0, ->IDLE. Busy is therefore high for exactly LAT cycles (N+1..N+LAT).
  - RD completion edge: dout<=mem[idx] (combined read, same edge busy falls); if idx out of range, dout<=0 and fail<=1.
  - WR completion edge: for each i with mask[i]==0, mem[idx] byte i <= din byte i. total_written increments even if mask=4'hF. Out of range: no array write, no increment, fail<=1.
  - REF completion: no data effect.
- Re-acceptance: a request still high in IDLE after completion is accepted as a new operation. The initiator must drop its request on the edge it first sees busy=1. Minimum busy-low gap between two operations is 1 cycle.
- Read-after-write: a read accepted after a write completes returns the written data.
- Simultaneous requests in IDLE: only the highest-priority request is accepted. Lower-priority ones are not remembered and must still be asserted after completion to be served.
- dout is stable during busy and across writes and refreshes.
- fail clears only on reset.

Test Plan:
- Init: release rst at t0 -> busy=1 and mem_initialized=0 for 16 cycles, then busy=0 and mem_initialized=1; a read pulse at cycle 5 is ignored (no busy change).
- Write then read: write addr=0x40, din=0xDEADBEEF, mask=4'h0 -> busy high for 3 cycles, total_written=1; then read addr=0x43 -> busy high for 4 cycles, dout=0xDEADBEEF on the busy-falling edge.
- Byte mask: after the above, write addr=0x40, din=0x000000AA, mask=4'b1110 -> read gives 0xDEADBEAA; write din=0x11220000, mask=4'b0011 -> read gives 0x1122BEAA.
- Priority and refresh: assert refresh, write and read in the same IDLE cycle -> REF taken with busy high for 8 cycles; memory unchanged; total_written unchanged; next accepted op (requests held) is the write.
- Out of range: read addr=DEPTH_WORDS*4 -> dout=0, fail=1; a subsequent write there leaves total_written unchanged; fail stays 1 until reset.
- Reset mid-op: assert rst 1 cycle into a write to 0x80 -> busy=1, INIT restarts, fail=0, total_written=0; after init, read 0x80 returns the prior contents (write not committed).

Source files
------------

// File: rtl/tn_sdram_responder.sv
// BRAM-backed responder for the read/write/refresh busy-handshake memory protocol.
// Models init delay, per-operation latency, refresh occupancy and out-of-range faults.
module tn_sdram_responder #(
   parameter int DEPTH_WORDS = 4096,
   parameter int READ_LAT    = 4,
   parameter int WRITE_LAT   = 3,
   parameter int REFRESH_LAT = 8,
   parameter int INIT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic        refresh,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   input  logic [3:0]  mask,
   output logic [31:0] dout,
   output logic        busy,
   output logic        mem_initialized,
   output logic        fail,
   output logic [15:0] total_written
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WR, S_REF} state_t;

   state_t        state;
   logic [31:0]   cnt;
   logic [29:0]   idx;
   logic [31:0]   wdata;
   logic [3:0]    wmask;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          in_range;
   logic          done;
   logic          commit;
   logic [AW-1:0] widx;
   logic          unused_addr_bits;

   assign in_range         = (idx < 30'(DEPTH_WORDS));
   assign widx             = idx[AW-1:0];
   assign done             = (cnt == 32'd0);
   assign commit           = (state == S_WR) && done && in_range;
   assign unused_addr_bits = ^addr[1:0];

   // NOTE: the array has no reset so it maps onto block RAM; a write dropped by
   // reset is suppressed because commit depends on the reset-cleared state.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (!wmask[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // NOTE: all state is updated with nonblocking assignments so every register
   // samples the pre-edge values, matching the hardware it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_INIT;
         busy            <= 1'b1;
         mem_initialized <= 1'b0;
         dout            <= 32'd0;
         fail            <= 1'b0;
         total_written   <= 16'd0;
         cnt             <= 32'd0;
         idx             <= 30'd0;
         wdata           <= 32'd0;
         wmask           <= 4'hF;
      end else begin
         case (state)
            S_INIT: begin
               if (cnt == 32'(INIT_CYCLES - 1)) begin
                  state           <= S_IDLE;
                  busy            <= 1'b0;
                  mem_initialized <= 1'b1;
                  cnt             <= 32'd0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_IDLE: begin
               if (refresh || write || read) begin
                  idx   <= addr[31:2];
                  wdata <= din;
                  wmask <= mask;
                  busy  <= 1'b1;
               end
               // Only the highest-priority request is taken; others are not remembered.
               if (refresh) begin
                  state <= S_REF;
                  cnt   <= 32'(REFRESH_LAT - 1);
               end else if (write) begin
                  state <= S_WR;
                  cnt   <= 32'(WRITE_LAT - 1);
               end else if (read) begin
                  state <= S_RD;
                  cnt   <= 32'(READ_LAT - 1);
               end
            end
            default: begin
               if (done) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
                  if (state == S_RD) begin
                     if (in_range) begin
                        dout <= mem[widx];
                     end else begin
                        dout <= 32'd0;
                        fail <= 1'b1;
                     end
                  end
                  if (state == S_WR) begin
                     if (in_range) total_written <= total_written + 16'd1;
                     else          fail          <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tn_sdram_responder.sv
// Bench for tn_sdram_responder: directed protocol scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the responder.
module tb_tn_sdram_responder;

   localparam int DEPTH = 4096;
   localparam int RL    = 4;
   localparam int WL    = 3;
   localparam int FL    = 8;
   localparam int IC    = 16;
   localparam int K_RD  = 0;
   localparam int K_WR  = 1;
   localparam int K_REF = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic        refresh = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] din = 32'd0;
   logic [3:0]  mask = 4'hF;
   logic [31:0] dout;
   logic        busy;
   logic        mem_initialized;
   logic        fail;
   logic [15:0] total_written;

   int vectors = 0;
   int miscompares = 0;

   tn_sdram_responder #(
      .DEPTH_WORDS(DEPTH), .READ_LAT(RL), .WRITE_LAT(WL),
      .REFRESH_LAT(FL), .INIT_CYCLES(IC)
   ) dut (
      .clk(clk), .rst(rst), .read(read), .write(write), .refresh(refresh),
      .addr(addr), .din(din), .mask(mask), .dout(dout), .busy(busy),
      .mem_initialized(mem_initialized), .fail(fail), .total_written(total_written)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Transaction-level model: remaining busy cycles plus the pending operation,
   // whose whole effect is applied when its busy window ends.
   int              m_init_left = IC;
   int              m_busy_left = 0;
   int              m_kind = K_REF;
   logic [29:0]     m_idx = 30'd0;
   logic [31:0]     m_din = 32'd0;
   logic [3:0]      m_mask = 4'hF;
   logic [31:0]     m_dout = 32'd0;
   logic            m_fail = 1'b0;
   logic [15:0]     m_tw = 16'd0;
   logic            m_initd = 1'b0;
   logic [31:0]     m_mem [int];

   function automatic void model_complete();
      logic [31:0] word;
      if (m_kind == K_RD) begin
         if (m_idx < DEPTH) m_dout = m_mem.exists(int'(m_idx)) ? m_mem[int'(m_idx)] : 'x;
         else begin m_dout = 32'd0; m_fail = 1'b1; end
      end else if (m_kind == K_WR) begin
         if (m_idx < DEPTH) begin
            word = m_mem.exists(int'(m_idx)) ? m_mem[int'(m_idx)] : 'x;
            for (int i = 0; i < 4; i++) if (!m_mask[i]) word[8*i +: 8] = m_din[8*i +: 8];
            m_mem[int'(m_idx)] = word;
            m_tw = m_tw + 16'd1;
         end else begin
            m_fail = 1'b1;
         end
      end
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_init_left = IC; m_busy_left = 0; m_dout = 32'd0;
         m_fail = 1'b0; m_tw = 16'd0; m_initd = 1'b0;
      end else if (m_init_left > 0) begin
         m_init_left--;
         if (m_init_left == 0) m_initd = 1'b1;
      end else if (m_busy_left > 0) begin
         m_busy_left--;
         if (m_busy_left == 0) model_complete();
      end else if (refresh || write || read) begin
         m_kind      = refresh ? K_REF : (write ? K_WR : K_RD);
         m_busy_left = refresh ? FL : (write ? WL : RL);
         m_idx = addr[31:2]; m_din = din; m_mask = mask;
      end
   end

   always @(negedge clk) begin
      check("busy", 32'(busy), 32'(m_init_left > 0 || m_busy_left > 0));
      check("mem_initialized", 32'(mem_initialized), 32'(m_initd));
      check("fail", 32'(fail), 32'(m_fail));
      check("total_written", 32'(total_written), 32'(m_tw));
      check("dout", dout, m_dout);
   end

   // Initiator helpers, all entered and left at a falling edge.
   task automatic wait_idle();
      int guard = 0;
      while ((busy || !mem_initialized) && guard < 200) begin @(negedge clk); guard++; end
      check("idle_timeout", 32'(guard >= 200), 32'd0);
   endtask

   task automatic wait_accept();
      int guard = 0;
      do begin @(negedge clk); guard++; end while (!busy && guard < 200);
      check("accept_timeout", 32'(guard >= 200), 32'd0);
   endtask

   task automatic count_busy(output int cyc);
      cyc = 0;
      while (busy && cyc < 200) begin cyc++; @(negedge clk); end
   endtask

   task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int cyc);
      wait_idle();
      addr = a; din = d; mask = m;
      read = (kind == K_RD); write = (kind == K_WR); refresh = (kind == K_REF);
      wait_accept();
      read = 1'b0; write = 1'b0; refresh = 1'b0;
      count_busy(cyc);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int k;
      logic [31:0] a;
      logic [3:0] m;

      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_init", 32'(mem_initialized), 32'd0);
      check("rst_dout", dout, 32'd0);

      // Init window, with a read pulse in cycle 5 that must be ignored.
      rst = 1'b0;
      c = 0;
      while (busy && c < 100) begin
         c++;
         read = (c == 5);
         @(negedge clk);
      end
      read = 1'b0;
      check("init_busy_cycles", 32'(c), 32'd16);
      check("init_done", 32'(mem_initialized), 32'd1);

      // Write then read, then byte-masked updates.
      do_op(K_WR, 32'h40, 32'hDEADBEEF, 4'h0, c);
      check("wr_lat", 32'(c), 32'(WL));
      check("tw_after_wr", 32'(total_written), 32'd1);
      do_op(K_RD, 32'h43, 32'h0, 4'hF, c);
      check("rd_lat", 32'(c), 32'(RL));
      check("rd_data", dout, 32'hDEADBEEF);
      do_op(K_WR, 32'h40, 32'h000000AA, 4'b1110, c);
      do_op(K_RD, 32'h40, 32'h0, 4'hF, c);
      check("mask_lo", dout, 32'hDEADBEAA);
      do_op(K_WR, 32'h40, 32'h11220000, 4'b0011, c);
      do_op(K_RD, 32'h40, 32'h0, 4'hF, c);
      check("mask_hi", dout, 32'h1122BEAA);
      do_op(K_WR, 32'h80, 32'hCAFEF00D, 4'h0, c);

      // All three requests together: refresh first, then the held write, then the read.
      wait_idle();
      addr = 32'h40; din = 32'h12345678; mask = 4'h0;
      refresh = 1'b1; write = 1'b1; read = 1'b1;
      wait_accept();
      refresh = 1'b0;
      count_busy(c);
      check("ref_lat", 32'(c), 32'(FL));
      check("ref_tw", 32'(total_written), 32'd4);
      check("ref_dout", dout, 32'h1122BEAA);
      wait_accept();
      write = 1'b0;
      count_busy(c);
      check("prio_wr_lat", 32'(c), 32'(WL));
      check("prio_tw", 32'(total_written), 32'd5);
      wait_accept();
      read = 1'b0;
      count_busy(c);
      check("prio_rd_lat", 32'(c), 32'(RL));
      check("prio_rd_data", dout, 32'h12345678);

      // Out-of-range accesses.
      do_op(K_RD, DEPTH * 4, 32'h0, 4'hF, c);
      check("oor_dout", dout, 32'd0);
      check("oor_fail", 32'(fail), 32'd1);
      do_op(K_WR, DEPTH * 4, 32'hFFFFFFFF, 4'h0, c);
      check("oor_tw", 32'(total_written), 32'd5);
      do_op(K_RD, 32'h40, 32'h0, 4'hF, c);
      check("oor_fail_sticky", 32'(fail), 32'd1);

      // Reset one cycle into a write: the write must not commit.
      wait_idle();
      addr = 32'h80; din = 32'h55555555; mask = 4'h0; write = 1'b1;
      wait_accept();
      write = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd1);
      check("midrst_init", 32'(mem_initialized), 32'd0);
      check("midrst_fail", 32'(fail), 32'd0);
      check("midrst_tw", 32'(total_written), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      count_busy(c);
      check("reinit_cycles", 32'(c), 32'd16);
      do_op(K_RD, 32'h80, 32'h0, 4'hF, c);
      check("midrst_data", dout, 32'hCAFEF00D);

      // Preload a 32-word window, then randomized traffic inside it.
      for (int i = 16; i < 48; i++) do_op(K_WR, 32'(i * 4), $urandom, 4'h0, c);
      for (int n = 0; n < 250; n++) begin
         k = $urandom_range(0, 9);
         a = 32'((16 + $urandom_range(0, 31)) * 4 + $urandom_range(0, 3));
         m = 4'($urandom);
         if (k < 2) begin
            do_op(K_REF, a, $urandom, m, c);
            check("rand_ref_lat", 32'(c), 32'(FL));
         end else if (k < 6) begin
            do_op(K_WR, a, $urandom, m, c);
            check("rand_wr_lat", 32'(c), 32'(WL));
         end else begin
            do_op(K_RD, a, $urandom, m, c);
            check("rand_rd_lat", 32'(c), 32'(RL));
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Random out-of-range write near the top, then fail must stay set.
      a = 32'h4000 + 32'($urandom_range(0, 1000) * 4);
      do_op(K_WR, a, $urandom, 4'h0, c);
      do_op(K_RD, 32'h44, 32'h0, 4'hF, c);
      check("final_fail", 32'(fail), 32'd1);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
